// File: rtl/smart_toilet_pkg.sv
// rtl/smart_toilet_pkg.sv - shared state encoding and pump patterns for the smart-toilet sequencer
package smart_toilet_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEAD3  = 3'd1,
    LEAD2  = 3'd2,
    DISP   = 3'd3,
    MIX    = 3'd4,
    SAMPLE = 3'd5,
    DONE   = 3'd6,
    FLUSH  = 3'd7
  } state_t;

  localparam int P_SOLN1 = 0;
  localparam int P_SOLN2 = 1;
  localparam int P_SOLN3 = 2;

  localparam logic [2:0] PUMP_OFF   = 3'b000;
  localparam logic [2:0] PUMP_LEAD3 = 3'b100;
  localparam logic [2:0] PUMP_LEAD2 = 3'b110;
  localparam logic [2:0] PUMP_DISP  = 3'b111;
  localparam logic [2:0] PUMP_FLUSH = 3'b111;

  function automatic logic [2:0] pump_pat(input state_t s);
    case (s)
      LEAD3:   return PUMP_LEAD3;
      LEAD2:   return PUMP_LEAD2;
      DISP:    return PUMP_DISP;
      FLUSH:   return PUMP_FLUSH;
      default: return PUMP_OFF;
    endcase
  endfunction

endpackage

// File: rtl/st_phase_timer.sv
// rtl/st_phase_timer.sv - loadable down-counter that parks at zero
module st_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/smart_toilet_seq.sv
// rtl/smart_toilet_seq.sv - inlet pump / mix / sample sequencer; optional flush phase via SMART_TOILET_FLUSH_EN
module smart_toilet_seq
  import smart_toilet_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int SAMPLE_TO = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_lead3,
  input  logic [CNT_W-1:0] cfg_lead2,
  input  logic [CNT_W-1:0] cfg_disp,
  input  logic [CNT_W-1:0] cfg_mix,
`ifdef SMART_TOILET_FLUSH_EN
  input  logic [CNT_W-1:0] cfg_flush,
`endif
  output logic [2:0]       pump_en,
  output logic             sample_req,
  input  logic             sample_ack,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [2:0]       state_o
);

  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(SAMPLE_TO - 1);

  state_t           state, nxt, exit_st;
  logic [CNT_W-1:0] lead2_q, disp_q, mix_q;
  logic             tmr_load, tmr_zero, to_load, to_zero, set_err, accept;
  logic [CNT_W-1:0] tmr_val;

  // A phase of length max(cfg,1) needs the counter to start at cfg-1.
  function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

`ifdef SMART_TOILET_FLUSH_EN
  logic [CNT_W-1:0] flush_q;
  assign exit_st = FLUSH;
`else
  assign exit_st = IDLE;
`endif

  assign accept = (state == IDLE) && start;

  always_comb begin
    nxt      = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    to_load  = 1'b0;
    set_err  = 1'b0;
    case (state)
      IDLE:   if (start)    begin nxt = LEAD3; tmr_load = 1'b1; tmr_val = ld(cfg_lead3); end
      LEAD3:  if (tmr_zero) begin nxt = LEAD2; tmr_load = 1'b1; tmr_val = ld(lead2_q); end
      LEAD2:  if (tmr_zero) begin nxt = DISP;  tmr_load = 1'b1; tmr_val = ld(disp_q); end
      DISP:   if (tmr_zero) begin nxt = MIX;   tmr_load = 1'b1; tmr_val = ld(mix_q); end
      MIX:    if (tmr_zero) begin nxt = SAMPLE; to_load = 1'b1; end
      SAMPLE: begin
        if (sample_ack)   nxt = DONE;
        else if (to_zero) begin nxt = DONE; set_err = 1'b1; end
      end
      DONE: begin
        nxt = exit_st;
`ifdef SMART_TOILET_FLUSH_EN
        tmr_load = 1'b1;
        tmr_val  = ld(flush_q);
`endif
      end
      FLUSH:  if (tmr_zero) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // abort wins over any expiry; the flush phase itself is not abortable
    if (abort && state != IDLE && state != FLUSH) begin
      nxt      = exit_st;
      set_err  = 1'b0;
      to_load  = 1'b0;
`ifdef SMART_TOILET_FLUSH_EN
      tmr_load = 1'b1;
      tmr_val  = ld(flush_q);
`else
      tmr_load = 1'b0;
      tmr_val  = '0;
`endif
    end
  end

  st_phase_timer #(.CNT_W(CNT_W)) u_phase (
    .clk(clk), .rst_n(rst_n), .load(tmr_load), .load_val(tmr_val), .zero(tmr_zero)
  );

  st_phase_timer #(.CNT_W(CNT_W)) u_timeout (
    .clk(clk), .rst_n(rst_n), .load(to_load), .load_val(TO_LOAD), .zero(to_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pump_en     <= PUMP_OFF;
      sample_req  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      lead2_q     <= '0;
      disp_q      <= '0;
      mix_q       <= '0;
`ifdef SMART_TOILET_FLUSH_EN
      flush_q     <= '0;
`endif
    end else begin
      state      <= nxt;
      pump_en    <= pump_pat(nxt);
      sample_req <= (nxt == SAMPLE);
      busy       <= (nxt != IDLE);
      done       <= (nxt == DONE);
      if (accept) begin
        err_timeout <= 1'b0;
        lead2_q     <= cfg_lead2;
        disp_q      <= cfg_disp;
        mix_q       <= cfg_mix;
`ifdef SMART_TOILET_FLUSH_EN
        flush_q     <= cfg_flush;
`endif
      end else if (set_err) begin
        err_timeout <= 1'b1;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_smart_toilet_seq.sv
// tb/tb_smart_toilet_seq.sv - directed self-checking bench for smart_toilet_seq
module tb_smart_toilet_seq;

  localparam int SAMPLE_TO = 1000;
`ifdef SMART_TOILET_FLUSH_EN
  localparam int FL = 6;
`else
  localparam int FL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, start, abort, sample_ack;
  logic [15:0] cfg_lead3, cfg_lead2, cfg_disp, cfg_mix, cfg_flush;
  logic [2:0]  pump_en, state_o;
  logic        sample_req, busy, done, err_timeout;

  int checks = 0;
  int failures = 0;
  int c100, c110, c111, cmix, cfl, nreq, ndone, nbusy, last_idx;
  logic [2:0] first_pump, ab_pump, lst_pump, lst_state;
  logic       first_err, err_last, ab_busy, ab_req, lst_req, lst_done, lst_err;

  smart_toilet_seq #(.CNT_W(16), .SAMPLE_TO(SAMPLE_TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_lead3(cfg_lead3), .cfg_lead2(cfg_lead2), .cfg_disp(cfg_disp), .cfg_mix(cfg_mix),
`ifdef SMART_TOILET_FLUSH_EN
    .cfg_flush(cfg_flush),
`endif
    .pump_en(pump_en), .sample_req(sample_req), .sample_ack(sample_ack),
    .busy(busy), .done(done), .err_timeout(err_timeout), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ack_mode 0: ack on the second sample_req cycle; 1: never ack. *_at < 0 disables that event.
  task automatic run(input logic [15:0] l3, input logic [15:0] l2, input logic [15:0] d,
                     input logic [15:0] m, input int ack_mode, input int start_at,
                     input int chg_at, input int abort_at, input int rst_at);
    logic done_seen, aborted;
    c100 = 0; c110 = 0; c111 = 0; cmix = 0; cfl = 0; nreq = 0; ndone = 0; nbusy = 0;
    done_seen = 0; aborted = 0; err_last = 0; ab_pump = 0; ab_busy = 0; ab_req = 0;
    cfg_lead3 = l3; cfg_lead2 = l2; cfg_disp = d; cfg_mix = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    last_idx = 1200;
    for (int idx = 0; idx < 1200; idx++) begin
      if (idx == 0) begin first_pump = pump_en; first_err = err_timeout; end
      if (idx == abort_at + 1) begin ab_pump = pump_en; ab_busy = busy; ab_req = sample_req; end
      if (!busy) begin last_idx = idx; break; end
      nbusy++;
      if (done) begin ndone++; done_seen = 1; end
      if (sample_req) begin
        nreq++;
        if (nreq == SAMPLE_TO) err_last = err_timeout;
      end
      case (pump_en)
        3'b100: c100++;
        3'b110: c110++;
        3'b111: if (done_seen || aborted) cfl++; else c111++;
        3'b000: if (!sample_req && !done) cmix++;
        default: ;
      endcase
      sample_ack = (ack_mode == 0) && sample_req && (nreq >= 2);
      start = (idx == start_at);
      abort = (idx == abort_at);
      if (idx == abort_at) aborted = 1;
      rst_n = !(idx == rst_at);
      if (idx == chg_at) begin
        cfg_lead3 = 16'd9; cfg_lead2 = 16'd9; cfg_disp = 16'd9; cfg_mix = 16'd9; cfg_flush = 16'd9;
      end
      tick();
    end
    lst_pump = pump_en; lst_req = sample_req; lst_done = done; lst_err = err_timeout; lst_state = state_o;
    chk("run_ends_idle", busy, 0);
    start = 0; abort = 0; rst_n = 1; sample_ack = 0; cfg_flush = 16'd6;
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; sample_ack = 0;
    cfg_lead3 = 0; cfg_lead2 = 0; cfg_disp = 0; cfg_mix = 0; cfg_flush = 16'd6;
    tick(); tick();
    chk("rst_pump", pump_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", sample_req, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_state", state_o, 0);
    rst_n = 1;
    tick();

    // 1: nominal timings
    run(16'd4, 16'd3, 16'd5, 16'd2, 0, -1, -1, -1, -1);
    chk("t1_first_pump", first_pump, 3'b100);
    chk("t1_lead3", c100, 4);
    chk("t1_lead2", c110, 3);
    chk("t1_disp", c111, 5);
    chk("t1_mix", cmix, 2);
    chk("t1_req", nreq, 2);
    chk("t1_done", ndone, 1);
    chk("t1_busy", nbusy, 17 + FL);
    chk("t1_flush", cfl, FL);
    chk("t1_err", lst_err, 0);

    // 2: zero configs collapse every phase to one cycle
    run(16'd0, 16'd0, 16'd0, 16'd0, 0, -1, -1, -1, -1);
    chk("t2_lead3", c100, 1);
    chk("t2_lead2", c110, 1);
    chk("t2_disp", c111, 1);
    chk("t2_mix", cmix, 1);
    chk("t2_done", ndone, 1);
    chk("t2_busy", nbusy, 7 + FL);

    // 3: no ack -> timeout after SAMPLE_TO cycles, then start clears the flag
    run(16'd1, 16'd1, 16'd1, 16'd1, 1, -1, -1, -1, -1);
    chk("t3_req_cycles", nreq, SAMPLE_TO);
    chk("t3_err_before", err_last, 0);
    chk("t3_done", ndone, 1);
    chk("t3_err_after", lst_err, 1);
    chk("t3_busy", nbusy, 4 + SAMPLE_TO + 1 + FL);
    run(16'd1, 16'd1, 16'd1, 16'd1, 0, -1, -1, -1, -1);
    chk("t3_err_cleared", first_err, 0);
    chk("t3_rerun_done", ndone, 1);

    // 4: abort on the second DISP cycle
    run(16'd1, 16'd1, 16'd5, 16'd2, 0, -1, -1, 3, -1);
    chk("t4_disp", c111, 2);
    chk("t4_done", ndone, 0);
    chk("t4_abort_pump", ab_pump, (FL != 0) ? 3'b111 : 3'b000);
    chk("t4_abort_req", ab_req, 0);
    chk("t4_abort_busy", ab_busy, (FL != 0) ? 1 : 0);
    chk("t4_flush", cfl, FL);
    chk("t4_busy", nbusy, 4 + FL);

    // 5: one-cycle reset on the second MIX cycle
    run(16'd2, 16'd2, 16'd2, 16'd5, 0, -1, -1, -1, 7);
    chk("t5_mix_before", cmix, 2);
    chk("t5_pump", lst_pump, 0);
    chk("t5_req", lst_req, 0);
    chk("t5_done", lst_done, 0);
    chk("t5_state", lst_state, 0);
    chk("t5_ndone", ndone, 0);

    // 6: start while busy ignored; cfg changes after the start edge have no effect
    run(16'd3, 16'd2, 16'd4, 16'd1, 0, 1, 1, -1, -1);
    chk("t6_lead3", c100, 3);
    chk("t6_lead2", c110, 2);
    chk("t6_disp", c111, 4);
    chk("t6_mix", cmix, 1);
    chk("t6_done", ndone, 1);
    chk("t6_busy", nbusy, 13 + FL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
